// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel array readout path.
package pixel_pkg;

    // Default code width and number of read phases per frame.
    localparam int unsigned PIX_DATA_W   = 8;
    localparam int unsigned PIX_NUM_READ = 4;

    // Width the Gray/binary helpers operate on; callers zero-extend narrower codes.
    localparam int unsigned CODE_MAX_W   = 32;

    typedef enum logic [1:0] {
        RO_IDLE,
        RO_CONV,
        RO_READ
    } ro_state_e;

    // Binary to reflected Gray code.
    function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR from the MSB down. Zero-extended upper bits stay zero.
    function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] g);
        logic [CODE_MAX_W-1:0] b;
        b[CODE_MAX_W-1] = g[CODE_MAX_W-1];
        for (int i = CODE_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO for readout samples. A push into a full FIFO is dropped
// unless a pop happens in the same cycle; the drop is flagged combinationally.
module readout_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Pop of an empty FIFO is ignored; a full FIFO accepts a push only alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head is forced to zero when empty so the output is clean after reset/flush.
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout: drives the Gray ramp during convert, captures each row's latched
// code at the end of its read phase, converts it to binary and queues it for output.
module pixel_readout
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_W     = PIX_DATA_W,
    parameter int unsigned NUM_READ   = PIX_NUM_READ,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              convert,
    input  logic [NUM_READ-1:0]                               read_en,
    input  logic [DATA_W-1:0]                                 pix_data,
    output logic [DATA_W-1:0]                                 ramp_gray,
    output logic [DATA_W-1:0]                                 out_data,
    output logic [((NUM_READ > 1) ? $clog2(NUM_READ) : 1)-1:0] out_idx,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              frame_done,
    output logic                                              overflow,
    output logic                                              protocol_err
);

    localparam int unsigned IDX_W = (NUM_READ > 1) ? $clog2(NUM_READ) : 1;
    localparam logic [DATA_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_READ - 1);

    // Registered inputs.
    logic                convert_q;
    logic [NUM_READ-1:0] read_q;
    logic [DATA_W-1:0]   pix_q;

    // Ramp counter.
    logic [DATA_W-1:0]     cnt_q;
    logic [CODE_MAX_W-1:0] cnt_gray_w;
    logic [CODE_MAX_W-1:0] pix_bin_w;

    // Control.
    ro_state_e           state_q;
    logic [IDX_W-1:0]    exp_idx_q;
    logic                push_q;
    logic [IDX_W-1:0]    push_idx_q;
    logic [DATA_W-1:0]   push_data_q;

    logic                conv_rise;
    logic                conv_fall;
    logic [NUM_READ-1:0] cap_vec;
    logic                cap_any;
    logic [IDX_W-1:0]    cap_idx;
    logic                multi_hot;
    logic                err_set;
    logic                sticky_clr;

    logic                fifo_empty;
    logic                fifo_drop;
    logic                unused_fifo_full;
    logic                unused_code_hi;

    assign conv_rise = convert && !convert_q;
    assign conv_fall = !convert && convert_q;
    assign multi_hot = |(read_en & (read_en - 1'b1));

    // Helpers work on a wide word; DATA_W must stay below CODE_MAX_W.
    assign cnt_gray_w     = bin2gray(CODE_MAX_W'(cnt_q));
    assign pix_bin_w      = gray2bin(CODE_MAX_W'(pix_q));
    assign unused_code_hi = ^{cnt_gray_w[CODE_MAX_W-1:DATA_W], pix_bin_w[CODE_MAX_W-1:DATA_W]};

    // Input registers used for edge detection and capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            convert_q <= 1'b0;
            read_q    <= '0;
            pix_q     <= '0;
        end else begin
            convert_q <= convert;
            read_q    <= read_en;
            pix_q     <= pix_data;
        end
    end

    // Ramp counter restarts on convert rise and saturates; registered Gray output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            ramp_gray <= '0;
        end else begin
            if (conv_rise) begin
                cnt_q <= '0;
            end else if (convert_q && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            ramp_gray <= cnt_gray_w[DATA_W-1:0];
        end
    end

    // Capture on a read falling edge; lowest index wins if several fall together.
    always_comb begin
        cap_vec = read_q & ~read_en;
        cap_any = 1'b0;
        cap_idx = '0;
        for (int i = NUM_READ - 1; i >= 0; i--) begin
            if (cap_vec[i]) begin
                cap_any = 1'b1;
                cap_idx = IDX_W'(i);
            end
        end
    end

    // Protocol error sources and the sticky-flag clear condition.
    always_comb begin
        err_set    = multi_hot;
        sticky_clr = (state_q == RO_IDLE) && conv_rise;
        unique case (state_q)
            RO_IDLE, RO_CONV: begin
                if (cap_any) err_set = 1'b1;
            end
            RO_READ: begin
                if (conv_rise) begin
                    err_set = 1'b1;
                end else if (cap_any && (cap_idx != exp_idx_q)) begin
                    err_set = 1'b1;
                end
            end
            default: err_set = 1'b1;
        endcase
    end

    // Phase FSM with registered push strobe, frame_done and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RO_IDLE;
            exp_idx_q    <= '0;
            push_q       <= 1'b0;
            push_idx_q   <= '0;
            push_data_q  <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            frame_done <= 1'b0;
            // Set wins over clear.
            protocol_err <= err_set || (protocol_err && !sticky_clr);
            overflow     <= fifo_drop || (overflow && !sticky_clr);
            unique case (state_q)
                RO_IDLE: begin
                    if (conv_rise) state_q <= RO_CONV;
                end
                RO_CONV: begin
                    if (conv_fall) begin
                        state_q   <= RO_READ;
                        exp_idx_q <= '0;
                    end
                end
                RO_READ: begin
                    if (conv_rise) begin
                        // Frame abandoned.
                        state_q <= RO_CONV;
                    end else if (cap_any) begin
                        push_q      <= 1'b1;
                        push_idx_q  <= cap_idx;
                        push_data_q <= pix_bin_w[DATA_W-1:0];
                        exp_idx_q   <= cap_idx + 1'b1;
                        if (cap_idx == LAST_IDX) begin
                            state_q    <= RO_IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state_q <= RO_IDLE;
            endcase
        end
    end

    readout_fifo #(
        .WIDTH (IDX_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data ({push_idx_q, push_data_q}),
        .pop       (out_ready),
        .pop_data  ({out_idx, out_data}),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: ramp, full frames, saturation, overflow,
// out-of-order reads and mid-frame reset.
module tb_pixel_readout;
    import pixel_pkg::*;

    localparam int DW = PIX_DATA_W;
    localparam int NR = PIX_NUM_READ;

    logic          clk;
    logic          reset;
    logic          convert;
    logic [NR-1:0] read_en;
    logic [DW-1:0] pix_data;
    logic [DW-1:0] ramp_gray;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;
    logic          overflow;
    logic          protocol_err;

    int checks   = 0;
    int failures = 0;

    pixel_readout #(
        .DATA_W     (DW),
        .NUM_READ   (NR),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .convert      (convert),
        .read_en      (read_en),
        .pix_data     (pix_data),
        .ramp_gray    (ramp_gray),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle 1ns past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Convert for n edges, then leave two edges so the FSM reaches READ.
    task automatic conv(input int n);
        convert = 1'b1;
        step(n);
        convert = 1'b0;
        step(2);
    endtask

    // Hold read k for two edges with Gray value g, then drop it.
    task automatic read_row(input int k, input logic [7:0] g);
        read_en  = NR'(1 << k);
        pix_data = g;
        step(2);
        read_en = '0;
    endtask

    // One frame with out_ready=1, checking latency, data, index and frame_done.
    task automatic frame_check(input string name);
        logic [7:0] g [4];
        logic [7:0] b [4];
        g = '{8'h0F, 8'h3C, 8'hFF, 8'h80};
        b = '{8'h0A, 8'h28, 8'hAA, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            read_row(k, g[k]);
            step(1);
            chk($sformatf("%s_fd_push%0d", name, k), frame_done, (k == 3) ? 1 : 0);
            chk($sformatf("%s_early%0d", name, k), out_valid, 0);
            step(1);
            chk($sformatf("%s_valid%0d", name, k), out_valid, 1);
            chk($sformatf("%s_data%0d", name, k), out_data, b[k]);
            chk($sformatf("%s_idx%0d", name, k), out_idx, k);
            chk($sformatf("%s_fd_after%0d", name, k), frame_done, 0);
            step(1);
            chk($sformatf("%s_drained%0d", name, k), out_valid, 0);
        end
        chk($sformatf("%s_perr", name), protocol_err, 0);
        chk($sformatf("%s_ovf", name), overflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ramp_tbl [11];
        logic [7:0] ga [4];
        logic [7:0] gb [4];
        logic [7:0] ba [4];
        ramp_tbl = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4, 8'd12, 8'd13, 8'd15};
        ga = '{8'h01, 8'h02, 8'h04, 8'h08};
        ba = '{8'h01, 8'h03, 8'h07, 8'h0F};
        gb = '{8'h55, 8'hAA, 8'h33, 8'hCC};

        reset     = 1'b1;
        convert   = 1'b0;
        read_en   = '0;
        pix_data  = '0;
        out_ready = 1'b1;
        step(2);
        chk("rst_ramp", ramp_gray, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", protocol_err, 0);
        reset = 1'b0;
        step(1);

        // Ramp sequence over a 10-cycle convert.
        convert = 1'b1;
        step(1);
        for (int i = 0; i < 11; i++) begin
            step(1);
            chk($sformatf("ramp%0d", i), ramp_gray, ramp_tbl[i]);
            if (i == 8) convert = 1'b0;
        end
        step(3);
        chk("ramp_hold", ramp_gray, 8'd15);
        chk("ramp_perr", protocol_err, 0);
        chk("ramp_ovf", overflow, 0);

        // First full frame directly after the convert above.
        frame_check("f1");

        // Ramp saturation.
        convert = 1'b1;
        step(300);
        chk("sat_ramp", ramp_gray, 8'h80);
        convert = 1'b0;
        step(3);
        chk("sat_hold", ramp_gray, 8'h80);
        chk("sat_perr", protocol_err, 0);

        // Two frames without draining: second frame overflows.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            read_row(k, ga[k]);
            step(2);
        end
        chk("ovf_before", overflow, 0);
        chk("ovf_head_a", out_data, ba[0]);
        conv(3);
        for (int k = 0; k < 4; k++) begin
            read_row(k, gb[k]);
            step(2);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_head_valid", out_valid, 1);
        chk("ovf_head_data", out_data, ba[0]);
        chk("ovf_head_idx", out_idx, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_valid%0d", i), out_valid, 1);
            chk($sformatf("drain_data%0d", i), out_data, ba[i]);
            chk($sformatf("drain_idx%0d", i), out_idx, i);
            step(1);
        end
        chk("drain_empty", out_valid, 0);

        // Skipped reads: read3 straight after convert.
        conv(3);
        chk("skip_ovf_clr", overflow, 0);
        read_row(2, 8'hC3);
        step(1);
        chk("skip_perr", protocol_err, 1);
        chk("skip_fd", frame_done, 0);
        step(1);
        chk("skip_valid", out_valid, 1);
        chk("skip_data", out_data, 8'h82);
        chk("skip_idx", out_idx, 2);
        chk("skip_exp_idx", dut.exp_idx_q, 3);
        step(1);
        read_row(3, 8'h00);
        step(1);
        chk("skip_fd4", frame_done, 1);
        step(1);
        chk("skip_valid4", out_valid, 1);
        chk("skip_data4", out_data, 8'h00);
        chk("skip_idx4", out_idx, 3);
        step(1);

        // Reset during read2 with one entry queued and an error pending.
        out_ready = 1'b0;
        conv(3);
        chk("mr_perr_clr", protocol_err, 0);
        read_row(0, 8'h0F);
        step(2);
        chk("mr_queued", out_valid, 1);
        read_en  = 4'b0010;
        pix_data = 8'h3C;
        step(1);
        read_en = 4'b0110;
        step(1);
        chk("mr_multihot", protocol_err, 1);
        chk("mr_ramp_pre", ramp_gray, 8'd2);
        #2;
        reset   = 1'b1;
        read_en = '0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_idx", out_idx, 0);
        chk("mr_perr", protocol_err, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_fd", frame_done, 0);
        chk("mr_ramp", ramp_gray, 0);
        step(2);
        reset = 1'b0;
        step(1);
        out_ready = 1'b1;
        conv(3);
        frame_check("f3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
